// File: rtl/lpif_pkg.sv
// Shared LPIF types: PHY state encoding, packer FSM states, per-beat struct.
// No logic; latency n/a.
// Backpressure n/a.
package lpif_pkg;

  // PHY state as reported on pl_state_sts.
  typedef enum logic [3:0] {
    RESET     = 4'h0,
    ACTIVE    = 4'h1,
    LINKERROR = 4'hA,
    RETRAIN   = 4'hB
  } lpif_state_e;

  localparam lpif_state_e LPIF_STS_ACTIVE = ACTIVE;

  // Packer FSM: IDLE waits for a start byte, FILL is inside an open packet.
  typedef enum logic {
    PK_IDLE = 1'b0,
    PK_FILL = 1'b1
  } pk_state_e;

endpackage

// Beat word for an NB_-lane bus; byte k of data sits in bits [8k+7:8k].
`ifndef LPIF_BEAT_T
`define LPIF_BEAT_T(NB_) struct packed { \
    logic [8*(NB_)-1:0] data;      \
    logic [(NB_)-1:0]   valid;     \
    logic [(NB_)-1:0]   tlp_start; \
    logic [(NB_)-1:0]   tlp_end;   \
    logic [(NB_)-1:0]   dllp_start;\
    logic [(NB_)-1:0]   dllp_end;  \
    logic [(NB_)-1:0]   tlpedb;    \
  }
`endif

// File: rtl/lpif_beat_fifo.sv
// Synchronous beat FIFO with up to two pushes per cycle and a flush.
// Latency: a pushed word is visible at the head the cycle after its push edge.
// Backpressure: caller checks full/almost_full; pop and push may coincide when full.
module lpif_beat_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         push2_i,
  input  logic [W-1:0] din2_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         almost_full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_LVL = (AW + 1)'(DEPTH - 1);

  logic [AW:0]   wp_q, rp_q, wp_d, rp_d, cnt;
  logic [AW-1:0] wr_idx, wr_idx2;
  logic [W-1:0]  mem_q [DEPTH];

  assign cnt           = wp_q - rp_q;
  assign empty_o       = (wp_q == rp_q);
  assign full_o        = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign almost_full_o = (cnt >= AF_LVL);
  assign dout_o        = mem_q[rp_q[AW-1:0]];
  assign wr_idx        = wp_q[AW-1:0];
  assign wr_idx2       = wp_q[AW-1:0] + AW'(1);

  // Pointer advance; flush drops every stored word at once.
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (flush_i) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      wp_d = wp_q + {{AW{1'b0}}, push_i} + {{AW{1'b0}}, push2_i};
      rp_d = rp_q + {{AW{1'b0}}, pop_i};
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage needs no reset: the head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_idx] <= din_i;
    if (push2_i && !flush_i) mem_q[wr_idx2] <= din2_i;
  end

endmodule

// File: rtl/lpif_tx_packer.sv
// Packs link-layer bytes into LPIF beats with lane markers and queues them for the PHY.
// Latency: a beat closed on an edge raises lp_irdy the following cycle.
// Backpressure: in_ready drops when the beat FIFO lacks room or the link is not active.
module lpif_tx_packer
  import lpif_pkg::*;
#(
  parameter int LPIF_BUS_WIDTH = 64,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        lclk,
  input  logic                        reset_n,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sop,
  input  logic                        in_eop,
  input  logic                        in_is_dllp,
  input  logic                        in_edb,
  input  logic                        pl_linkup,
  input  logic [3:0]                  pl_state_sts,
  input  logic                        pl_trdy,
  output logic                        lp_irdy,
  output logic [LPIF_BUS_WIDTH-1:0]   lp_data,
  output logic [LPIF_BUS_WIDTH/8-1:0] lp_valid,
  output logic [LPIF_BUS_WIDTH/8-1:0] lp_tlp_start,
  output logic [LPIF_BUS_WIDTH/8-1:0] lp_tlp_end,
  output logic [LPIF_BUS_WIDTH/8-1:0] lp_dllp_start,
  output logic [LPIF_BUS_WIDTH/8-1:0] lp_dllp_end,
  output logic [LPIF_BUS_WIDTH/8-1:0] lp_tlpedb,
  output logic [15:0]                 drop_cnt,
  output logic                        err_pulse
);
  localparam int NB = LPIF_BUS_WIDTH / 8;
  localparam int LW = $clog2(NB);

  typedef `LPIF_BEAT_T(NB) lpif_beat_t;
  localparam int BW = $bits(lpif_beat_t);

  pk_state_e     state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  lpif_beat_t    beat_q, beat_d, nb_c, head, out_beat;
  lpif_beat_t    p0_dat, p1_dat;
  logic          p0_vld, p1_vld;
  logic          dllp_q, dllp_d, run_q, err_q, err_d, drop_inc, room;
  logic [15:0]   drop_q;
  logic          link_active, pop, acc;
  logic          fifo_full, fifo_empty, fifo_afull;
  logic [BW-1:0] head_bits;

  function automatic lpif_beat_t put_byte(lpif_beat_t b, logic [LW-1:0] lane, logic [7:0] d);
    lpif_beat_t r;
    r = b;
    r.data[8*lane +: 8] = d;
    r.valid[lane]       = 1'b1;
    return r;
  endfunction

  function automatic lpif_beat_t mark_end(lpif_beat_t b, logic [LW-1:0] lane, logic dllp, logic edb);
    lpif_beat_t r;
    r = b;
    if (dllp) begin
      r.dllp_end[lane] = 1'b1;
    end else begin
      r.tlp_end[lane] = 1'b1;
      r.tlpedb[lane]  = edb;
    end
    return r;
  endfunction

  assign link_active = pl_linkup && (pl_state_sts == 4'(LPIF_STS_ACTIVE));
  assign lp_irdy     = link_active && !fifo_empty;
  assign pop         = lp_irdy && pl_trdy;
  assign acc         = in_valid && in_ready;
  assign in_ready    = run_q && link_active && room;

  // A byte in FILL may close two beats (terminated packet + new one), so reserve two slots.
  always_comb begin
    room = 1'b0;
    if (state_q == PK_FILL) room = !fifo_afull || (pop && !fifo_full);
    else                    room = !fifo_full || pop;
  end

  // Packer: place the accepted byte, set markers, decide which beats close this cycle.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    beat_d   = beat_q;
    dllp_d   = dllp_q;
    nb_c     = '0;
    p0_vld   = 1'b0;
    p0_dat   = '0;
    p1_vld   = 1'b0;
    p1_dat   = '0;
    err_d    = 1'b0;
    drop_inc = 1'b0;
    if (!link_active) begin
      state_d  = PK_IDLE;
      lane_d   = '0;
      beat_d   = '0;
      drop_inc = (state_q == PK_FILL) || !fifo_empty;
    end else if (acc) begin
      if (state_q == PK_FILL && !in_sop) begin
        nb_c = put_byte(beat_q, lane_q, in_data);
        if (in_eop) begin
          nb_c    = mark_end(nb_c, lane_q, dllp_q, in_edb && !dllp_q);
          err_d   = in_edb && dllp_q;
          p0_vld  = 1'b1;
          p0_dat  = nb_c;
          beat_d  = '0;
          lane_d  = '0;
          state_d = PK_IDLE;
        end else if (lane_q == LW'(NB - 1)) begin
          p0_vld = 1'b1;
          p0_dat = nb_c;
          beat_d = '0;
          lane_d = '0;
        end else begin
          beat_d = nb_c;
          lane_d = lane_q + LW'(1);
        end
      end else if (in_sop) begin
        if (state_q == PK_FILL) begin
          err_d    = 1'b1;
          drop_inc = 1'b1;
          // With lane 0 empty the open packet's last byte already left in a full beat;
          // nothing is left to mark, the packet is only counted as dropped.
          if (lane_q != '0) begin
            p0_vld = 1'b1;
            p0_dat = mark_end(beat_q, lane_q - LW'(1), dllp_q, !dllp_q);
          end
        end
        nb_c = put_byte('0, '0, in_data);
        if (in_is_dllp) nb_c.dllp_start[0] = 1'b1;
        else            nb_c.tlp_start[0]  = 1'b1;
        dllp_d = in_is_dllp;
        if (in_eop) begin
          nb_c  = mark_end(nb_c, '0, in_is_dllp, in_edb && !in_is_dllp);
          err_d = err_d || (in_edb && in_is_dllp);
          if (p0_vld) begin
            p1_vld = 1'b1;
            p1_dat = nb_c;
          end else begin
            p0_vld = 1'b1;
            p0_dat = nb_c;
          end
          beat_d  = '0;
          lane_d  = '0;
          state_d = PK_IDLE;
        end else begin
          beat_d  = nb_c;
          lane_d  = LW'(1);
          state_d = PK_FILL;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Packer state, error strobe and saturating drop counter.
  always_ff @(posedge lclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PK_IDLE;
      lane_q  <= '0;
      beat_q  <= '0;
      dllp_q  <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      beat_q  <= beat_d;
      dllp_q  <= dllp_d;
      run_q   <= 1'b1;
      err_q   <= err_d;
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  lpif_beat_fifo #(
    .W     (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i         (lclk),
    .rst_ni        (reset_n),
    .push_i        (p0_vld),
    .din_i         (p0_dat),
    .push2_i       (p1_vld),
    .din2_i        (p1_dat),
    .pop_i         (pop),
    .flush_i       (!link_active),
    .dout_o        (head_bits),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .almost_full_o (fifo_afull)
  );

  assign head     = lpif_beat_t'(head_bits);
  assign out_beat = lp_irdy ? head : '0;

  assign lp_data       = out_beat.data;
  assign lp_valid      = out_beat.valid;
  assign lp_tlp_start  = out_beat.tlp_start;
  assign lp_tlp_end    = out_beat.tlp_end;
  assign lp_dllp_start = out_beat.dllp_start;
  assign lp_dllp_end   = out_beat.dllp_end;
  assign lp_tlpedb     = out_beat.tlpedb;
  assign drop_cnt      = drop_q;
  assign err_pulse     = err_q;

endmodule

// File: tb/tb_lpif_tx_packer.sv
// Bench for lpif_tx_packer: 64-bit instance with beat scoreboard, plus a 32-bit instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Beats are compared whenever lp_irdy and pl_trdy are both high.
module tb_lpif_tx_packer;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  valid, ts, te, ds, de, edb;
  } exp_beat_t;

  logic        lclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_is_dllp = 1'b0, in_edb = 1'b0;
  logic        in_ready;
  logic        pl_linkup = 1'b1, pl_trdy = 1'b1;
  logic [3:0]  pl_state_sts = 4'h1;
  logic        lp_irdy, err_pulse;
  logic [63:0] lp_data;
  logic [7:0]  lp_valid, lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end, lp_tlpedb;
  logic [15:0] drop_cnt;

  logic [7:0]  in_data32 = '0;
  logic        in_valid32 = 1'b0, in_sop32 = 1'b0, in_eop32 = 1'b0, pl_trdy32 = 1'b0;
  logic        in_ready32, lp_irdy32, err_pulse32;
  logic [31:0] lp_data32;
  logic [3:0]  lp_valid32, lp_ts32, lp_te32, lp_ds32, lp_de32, lp_edb32;
  logic [15:0] drop_cnt32;

  int          n_checks = 0;
  int          n_fail = 0;
  exp_beat_t   sb[$];
  logic [15:0] exp_drop = '0;

  always #5 lclk = ~lclk;

  lpif_tx_packer #(.LPIF_BUS_WIDTH(64), .FIFO_DEPTH(4)) u_dut (
    .lclk(lclk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .in_eop(in_eop), .in_is_dllp(in_is_dllp), .in_edb(in_edb),
    .pl_linkup(pl_linkup), .pl_state_sts(pl_state_sts), .pl_trdy(pl_trdy), .lp_irdy(lp_irdy),
    .lp_data(lp_data), .lp_valid(lp_valid), .lp_tlp_start(lp_tlp_start), .lp_tlp_end(lp_tlp_end),
    .lp_dllp_start(lp_dllp_start), .lp_dllp_end(lp_dllp_end), .lp_tlpedb(lp_tlpedb),
    .drop_cnt(drop_cnt), .err_pulse(err_pulse)
  );

  lpif_tx_packer #(.LPIF_BUS_WIDTH(32), .FIFO_DEPTH(4)) u_dut32 (
    .lclk(lclk), .reset_n(reset_n), .in_data(in_data32), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_sop(in_sop32), .in_eop(in_eop32), .in_is_dllp(1'b0), .in_edb(1'b0),
    .pl_linkup(pl_linkup), .pl_state_sts(pl_state_sts), .pl_trdy(pl_trdy32), .lp_irdy(lp_irdy32),
    .lp_data(lp_data32), .lp_valid(lp_valid32), .lp_tlp_start(lp_ts32), .lp_tlp_end(lp_te32),
    .lp_dllp_start(lp_ds32), .lp_dllp_end(lp_de32), .lp_tlpedb(lp_edb32),
    .drop_cnt(drop_cnt32), .err_pulse(err_pulse32)
  );

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every beat handed to the PHY must match the oldest expected beat.
  always @(negedge lclk) begin
    if (reset_n && lp_irdy && pl_trdy) begin
      chk_eq("beat_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_beat_t e;
        e = sb.pop_front();
        chk_eq("beat_data", lp_data, e.data);
        chk_eq("beat_valid", lp_valid, e.valid);
        chk_eq("beat_tlp_start", lp_tlp_start, e.ts);
        chk_eq("beat_tlp_end", lp_tlp_end, e.te);
        chk_eq("beat_dllp_start", lp_dllp_start, e.ds);
        chk_eq("beat_dllp_end", lp_dllp_end, e.de);
        chk_eq("beat_tlpedb", lp_tlpedb, e.edb);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge lclk);
      #1;
    end
  endtask

  // Called 1 unit after a rising edge; returns 1 unit after the edge that took the byte.
  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop,
                           input logic dllp, input logic edb);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop; in_is_dllp = dllp; in_edb = edb;
    @(negedge lclk);
    while (!in_ready && n < 200) begin
      @(negedge lclk);
      n++;
    end
    chk_eq("in_ready_wait", in_ready, 1);
    @(posedge lclk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_is_dllp = 1'b0; in_edb = 1'b0;
  endtask

  // Model the beats of a whole packet, queue them, then send the bytes.
  task automatic send_pkt(input int len, input logic dllp, input logic edb, input logic [7:0] base);
    exp_beat_t e;
    int lane;
    e = '0;
    for (int i = 0; i < len; i++) begin
      lane = i % 8;
      e.data[8*lane +: 8] = base + 8'(i);
      e.valid[lane] = 1'b1;
      if (i == 0) begin
        if (dllp) e.ds[lane] = 1'b1; else e.ts[lane] = 1'b1;
      end
      if (i == len - 1) begin
        if (dllp) e.de[lane] = 1'b1;
        else begin
          e.te[lane] = 1'b1;
          e.edb[lane] = edb;
        end
      end
      if (lane == 7 || i == len - 1) begin
        sb.push_back(e);
        e = '0;
      end
    end
    for (int i = 0; i < len; i++)
      send_byte(base + 8'(i), i == 0, i == len - 1, dllp, edb && (i == len - 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick(1);
      n++;
    end
    chk_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_beat_t e;
    // Reset state
    #12;
    chk_eq("rst_in_ready", in_ready, 0);
    chk_eq("rst_lp_irdy", lp_irdy, 0);
    chk_eq("rst_lp_valid", lp_valid, 0);
    chk_eq("rst_lp_data", lp_data, 0);
    chk_eq("rst_drop_cnt", drop_cnt, 0);
    chk_eq("rst_err", err_pulse, 0);
    #5 reset_n = 1'b1;
    tick(2);
    chk_eq("ready_after_rst", in_ready, 1);

    // 3-byte TLP, beat presented one cycle after eop
    pl_trdy = 1'b1;
    send_pkt(3, 1'b0, 1'b0, 8'hA1);
    chk_eq("irdy_after_eop", lp_irdy, 1);
    drain();

    // 10-byte TLP with EDB
    send_pkt(10, 1'b0, 1'b1, 8'h10);
    drain();

    // DLLP then TLP queued with PHY stalled; head must hold
    pl_trdy = 1'b0;
    send_pkt(6, 1'b1, 1'b0, 8'h30);
    send_pkt(2, 1'b0, 1'b0, 8'h40);
    for (int i = 0; i < 3; i++) begin
      @(negedge lclk);
      chk_eq("hold_irdy", lp_irdy, 1);
      chk_eq("hold_data", lp_data, sb[0].data);
    end
    tick(1);
    pl_trdy = 1'b1;
    drain();

    // Fill FIFO with single-byte packets, then push while popping at full
    pl_trdy = 1'b0;
    for (int k = 0; k < 4; k++) send_pkt(1, 1'b0, 1'b0, 8'h90 + 8'(k));
    @(negedge lclk);
    chk_eq("full_no_ready", in_ready, 0);
    tick(1);
    pl_trdy = 1'b1;
    send_pkt(1, 1'b0, 1'b0, 8'h94);
    pl_trdy = 1'b0;
    @(negedge lclk);
    chk_eq("full_after_swap", in_ready, 0);
    tick(1);
    pl_trdy = 1'b1;
    drain();

    // Link loss with two beats queued and a packet open
    pl_trdy = 1'b0;
    send_pkt(1, 1'b0, 1'b0, 8'h50);
    send_pkt(1, 1'b0, 1'b0, 8'h51);
    send_byte(8'h52, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h53, 1'b0, 1'b0, 1'b0, 1'b0);
    pl_linkup = 1'b0;
    @(negedge lclk);
    chk_eq("linkdown_irdy", lp_irdy, 0);
    chk_eq("linkdown_ready", in_ready, 0);
    tick(1);
    sb.delete();
    exp_drop = exp_drop + 16'd1;
    chk_eq("linkdown_drop", drop_cnt, exp_drop);
    tick(1);
    chk_eq("linkdown_drop_once", drop_cnt, exp_drop);
    pl_linkup = 1'b1;
    @(negedge lclk);
    chk_eq("relink_empty", lp_irdy, 0);
    tick(1);
    pl_trdy = 1'b1;
    send_pkt(2, 1'b0, 1'b0, 8'h58);
    drain();

    // sop inside an open packet: terminated with EDB, new packet in next beat
    e = '0; e.data = 64'h626160; e.valid = 8'h07; e.ts = 8'h01; e.te = 8'h04; e.edb = 8'h04;
    sb.push_back(e);
    e = '0; e.data = 64'h70; e.valid = 8'h01; e.ts = 8'h01; e.te = 8'h01;
    sb.push_back(e);
    send_byte(8'h60, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h61, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h62, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h70, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_drop = exp_drop + 16'd1;
    chk_eq("midsop_err", err_pulse, 1);
    chk_eq("midsop_drop", drop_cnt, exp_drop);
    tick(1);
    chk_eq("err_one_cycle", err_pulse, 0);
    drain();

    // Stray byte without sop in IDLE
    send_byte(8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_eq("stray_err", err_pulse, 1);
    tick(2);
    chk_eq("stray_no_beat", lp_irdy, 0);
    chk_eq("stray_no_drop", drop_cnt, exp_drop);

    // EDB on a DLLP: marker suppressed, error raised
    send_pkt(2, 1'b1, 1'b1, 8'hA0);
    chk_eq("dllp_edb_err", err_pulse, 1);
    drain();

    // 32-bit bus: 5-byte TLP gives a full beat then a 1-byte beat
    for (int i = 0; i < 5; i++) begin
      in_valid32 = 1'b1; in_data32 = 8'h80 + 8'(i); in_sop32 = (i == 0); in_eop32 = (i == 4);
      @(negedge lclk);
      chk_eq("w32_ready", in_ready32, 1);
      @(posedge lclk);
      #1;
    end
    in_valid32 = 1'b0; in_sop32 = 1'b0; in_eop32 = 1'b0;
    chk_eq("w32_b1_valid", lp_valid32, 4'hF);
    chk_eq("w32_b1_start", lp_ts32, 4'h1);
    chk_eq("w32_b1_end", lp_te32, 4'h0);
    chk_eq("w32_b1_data", lp_data32, 32'h83828180);
    pl_trdy32 = 1'b1;
    tick(1);
    pl_trdy32 = 1'b0;
    chk_eq("w32_b2_valid", lp_valid32, 4'h1);
    chk_eq("w32_b2_end", lp_te32, 4'h1);
    chk_eq("w32_b2_start", lp_ts32, 4'h0);
    chk_eq("w32_b2_data", lp_data32, 32'h84);
    pl_trdy32 = 1'b1;
    tick(1);
    chk_eq("w32_empty", lp_irdy32, 0);

    // Reset mid-packet: immediate clear, partial beat never emitted
    send_byte(8'hC0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    chk_eq("midrst_drop", drop_cnt, 0);
    chk_eq("midrst_ready", in_ready, 0);
    #2 reset_n = 1'b1;
    tick(4);
    chk_eq("midrst_no_beat", lp_irdy, 0);
    chk_eq("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
